uart_cmd_framer: RTL
====================

// Module: uart_cmd_framer
// PURPOSE
//  Sequences the UART receiver: consumes each byte it presents, drives its clear-ready
//  handshake, and assembles 5-byte frames {SYNC, cmd, data_hi, data_lo, chksum} into
//  one validated command (8-bit opcode + 16-bit data).
//  Sits between the UART receiver and the command processor.
//  Rejects frames with a bad checksum or an inter-byte timeout.
// PARAMETERS
//  SYNC_BYTE    8'hAA  frame header value; other bytes seen in IDLE are dropped silently
//  TIMEOUT_CYC  65000  max clk cycles allowed between accepted bytes inside a frame (>=2)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  rx_rdy       in   1   UART receiver byte-ready level
//  rx_data      in   8   UART receiver byte; valid while rx_rdy=1
//  clr_rx_rdy   out  1   one-cycle pulse; clears the receiver's ready
//  clr_cmd_rdy  in   1   consumer acknowledge; clears cmd_rdy
//  cmd_rdy      out  1   validated command held on cmd/data
//  cmd          out  8   opcode of last valid frame
//  data         out  16  {data_hi,data_lo} of last valid frame
//  chk_err      out  1   one-cycle pulse: checksum mismatch, frame discarded
//  to_err       out  1   one-cycle pulse: inter-byte timeout, frame discarded
//  cmd_ovr      out  1   one-cycle pulse: new frame overwrote an unacknowledged command
// BEHAVIOUR
//  Reset: every output 0; cmd/data 0; state IDLE; internal regs cleared.
//  Byte accept: accept = rx_rdy & ~rx_rdy_q, where rx_rdy_q is rx_rdy registered.
//   - clr_rx_rdy is registered; it is high exactly on the cycle after accept.
//   - rx_rdy remaining high for the 1-2 cycles the receiver needs to drop it is never
//     re-accepted.
//  FSM states: IDLE, CMD, DHI, DLO, CHK. Transitions occur only on accept, except timeout.
//   - IDLE: accept & rx_data==SYNC_BYTE -> CMD; any other byte is dropped and the
//     state stays IDLE.
//   - CMD: accept -> latch cmd_sh; go to DHI.
//   - DHI: accept -> latch hi_sh; go to DLO.
//   - DLO: accept -> latch lo_sh; go to CHK.
//   - CHK: accept -> IDLE. The frame is valid iff
//     rx_data == (cmd_sh + hi_sh + lo_sh) mod 256, with 8-bit wrap and the SYNC byte
//     excluded from the sum.
//  A SYNC_BYTE value received in CMD/DHI/DLO/CHK is ordinary payload; there is no resync.
//  Valid frame, on the cycle after the CHK accept:
//   - cmd <= cmd_sh, data <= {hi_sh,lo_sh}, cmd_rdy <= 1.
//   - If cmd_rdy was already 1 and clr_cmd_rdy is 0 that cycle, cmd_ovr pulses.
//  Invalid frame: chk_err pulses the cycle after the CHK accept; cmd/data/cmd_rdy are
//  unchanged.
//  cmd_rdy:
//   - Cleared the cycle after clr_cmd_rdy=1.
//   - A set and a clr_cmd_rdy in the same cycle: set wins.
//   - cmd/data are stable whenever cmd_rdy=1 until the next valid frame.
//  Timeout: 16-bit counter.
//   - Zeroed in IDLE and on every accept; increments every cycle in CMD..CHK.
//   - When it reaches TIMEOUT_CYC-1 with no accept: to_err pulses next cycle, the FSM
//     goes to IDLE and the partial frame is discarded.
//   - An accept on that same cycle takes priority; there is no timeout.
//  Error pulses are mutually exclusive. A byte arriving while an error pulse is high is
//  processed from IDLE.
//  Async reset mid-frame: immediate return to IDLE, all outputs 0; the partial frame is
//  lost.
// TESTING
//  1. Bytes AA,05,12,34,4B (each rx_rdy held 3 cycles):
//     -> cmd_rdy=1, cmd=05, data=1234, one clr_rx_rdy pulse per byte.
//  2. Bytes AA,05,12,34,4C -> chk_err single pulse; cmd_rdy stays 0; cmd/data unchanged.
//  3. Bytes 00,FF,AA,80,90,F0,00 (sum wraps to 00)
//     -> two leading bytes dropped; cmd=80, data=90F0, cmd_rdy=1.
//  4. AA,01 then idle TIMEOUT_CYC cycles
//     -> to_err pulse; subsequent AA,02,00,01,03 -> cmd=02, data=0001.
//  5. Two valid frames back-to-back, no clr_cmd_rdy
//     -> cmd_ovr pulse, second frame's values shown.
//     Then clr_cmd_rdy=1 on the same cycle a third frame completes -> cmd_rdy stays 1.
//  6. Assert rst_n=0 after byte DHI -> all outputs 0 at once.
//     After release, a full valid frame decodes correctly.

Source files
------------

// File: rtl/uart_cmd_framer.sv
// Frames UART receiver bytes into validated 5-byte commands {SYNC, cmd, hi, lo, chksum}.
// Drives the receiver clear handshake and flags checksum, timeout and overwrite events.
module uart_cmd_framer #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 65000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        chk_err,
  output logic        to_err,
  output logic        cmd_ovr
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, CMD, DHI, DLO, CHK} state_e;

  state_e             state_q, state_d;
  logic               rx_rdy_q;
  logic               clr_rx_rdy_q, clr_rx_rdy_d;
  logic [7:0]         cmd_sh_q, cmd_sh_d;
  logic [7:0]         hi_sh_q, hi_sh_d;
  logic [7:0]         lo_sh_q, lo_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [15:0]        data_q, data_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               chk_err_q, chk_err_d;
  logic               to_err_q, to_err_d;
  logic               cmd_ovr_q, cmd_ovr_d;
  logic               accept_c;
  logic [7:0]         chk_sum_c;

  // Rising edge of the receiver ready level; a held level is never re-accepted.
  assign accept_c  = rx_rdy & ~rx_rdy_q;
  assign chk_sum_c = cmd_sh_q + hi_sh_q + lo_sh_q;

  always_comb begin
    state_d      = state_q;
    clr_rx_rdy_d = accept_c;
    cmd_sh_d     = cmd_sh_q;
    hi_sh_d      = hi_sh_q;
    lo_sh_d      = lo_sh_q;
    cnt_d        = (state_q == IDLE || accept_c) ? '0 : cnt_q + CNT_W'(1);
    cmd_d        = cmd_q;
    data_d       = data_q;
    cmd_rdy_d    = cmd_rdy_q & ~clr_cmd_rdy;
    chk_err_d    = 1'b0;
    to_err_d     = 1'b0;
    cmd_ovr_d    = 1'b0;

    case (state_q)
      IDLE: if (accept_c && rx_data == SYNC_BYTE) state_d = CMD;
      CMD: if (accept_c) begin
        cmd_sh_d = rx_data;
        state_d  = DHI;
      end
      DHI: if (accept_c) begin
        hi_sh_d = rx_data;
        state_d = DLO;
      end
      DLO: if (accept_c) begin
        lo_sh_d = rx_data;
        state_d = CHK;
      end
      CHK: if (accept_c) begin
        state_d = IDLE;
        if (rx_data == chk_sum_c) begin
          cmd_d     = cmd_sh_q;
          data_d    = {hi_sh_q, lo_sh_q};
          cmd_rdy_d = 1'b1;
          cmd_ovr_d = cmd_rdy_q & ~clr_cmd_rdy;
        end else begin
          chk_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept on the last allowed cycle wins over the timeout.
    if (state_q != IDLE && !accept_c && cnt_q == TO_LAST) begin
      state_d  = IDLE;
      to_err_d = 1'b1;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_rdy_q     <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      cmd_sh_q     <= '0;
      hi_sh_q      <= '0;
      lo_sh_q      <= '0;
      cnt_q        <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      cmd_rdy_q    <= 1'b0;
      chk_err_q    <= 1'b0;
      to_err_q     <= 1'b0;
      cmd_ovr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_rdy_q     <= rx_rdy;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      cmd_sh_q     <= cmd_sh_d;
      hi_sh_q      <= hi_sh_d;
      lo_sh_q      <= lo_sh_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      cmd_rdy_q    <= cmd_rdy_d;
      chk_err_q    <= chk_err_d;
      to_err_q     <= to_err_d;
      cmd_ovr_q    <= cmd_ovr_d;
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign cmd        = cmd_q;
  assign data       = data_q;
  assign chk_err    = chk_err_q;
  assign to_err     = to_err_q;
  assign cmd_ovr    = cmd_ovr_q;

endmodule
